// File: rtl/switch_event_arbiter_pkg.sv
// Shared encodings for the switch event arbiter: output FSM states,
// per-switch FIFO depth and the press/release event codes.
package switch_event_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    localparam int   FIFO_DEPTH = 2;
    localparam logic EV_PRESS   = 1'b1;
    localparam logic EV_RELEASE = 1'b0;

endpackage

// File: rtl/switch_event_arbiter_if.sv
// Switch inputs plus the single valid/ready event port shared by all switches.
interface switch_event_arbiter_if #(
    parameter int c_NUM_SWITCHES = 4,
    parameter int c_ID_WIDTH     = 2
);
    logic [c_NUM_SWITCHES-1:0] i_Switch;
    logic                      i_Ready;
    logic                      o_Event_Valid;
    logic [c_ID_WIDTH-1:0]     o_Event_Id;
    logic                      o_Event_Press;
    logic [c_NUM_SWITCHES-1:0] o_Overflow;

    modport master (
        input  i_Switch, i_Ready,
        output o_Event_Valid, o_Event_Id, o_Event_Press, o_Overflow
    );

    modport slave (
        output i_Switch, i_Ready,
        input  o_Event_Valid, o_Event_Id, o_Event_Press, o_Overflow
    );
endinterface

// File: rtl/switch_event_fifo.sv
// Two-entry, one-bit event FIFO for a single switch with a sticky drop flag.
module switch_event_fifo
    import switch_event_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic empty,
    output logic head,
    output logic overflow
);

    logic [FIFO_DEPTH-1:0] mem_r, mem_n;
    logic [1:0]            count_r, count_n;
    logic                  overflow_r, overflow_n;

    // Next contents: apply a pop first so a same-cycle push sees the freed slot
    always_comb begin
        mem_n      = mem_r;
        count_n    = count_r;
        overflow_n = overflow_r;
        if (pop && (count_r != 2'd0)) begin
            mem_n   = mem_r >> 1;
            count_n = count_r - 2'd1;
        end else begin
            count_n = count_r;
        end
        if (push) begin
            if (count_n == 2'(FIFO_DEPTH)) begin
                overflow_n = 1'b1;
            end else begin
                mem_n[count_n[0]] = push_data;
                count_n           = count_n + 2'd1;
            end
        end else begin
            overflow_n = overflow_r;
        end
    end

    // Storage, occupancy and sticky overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r      <= {FIFO_DEPTH{1'b0}};
            count_r    <= 2'd0;
            overflow_r <= 1'b0;
        end else begin
            mem_r      <= mem_n;
            count_r    <= count_n;
            overflow_r <= overflow_n;
        end
    end

    assign empty    = (count_r == 2'd0);
    assign head     = mem_r[0];
    assign overflow = overflow_r;

endmodule

// File: rtl/switch_event_arbiter.sv
// Edge detect per switch, one FIFO per switch, round-robin arbitration onto
// a single registered valid/ready event port.
module switch_event_arbiter
    import switch_event_arbiter_pkg::*;
#(
    parameter int c_NUM_SWITCHES = 4,
    parameter int c_ID_WIDTH     = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    switch_event_arbiter_if.master bus
);

    logic [c_NUM_SWITCHES-1:0] switch_s, prev_r, edge_s;
    logic [c_NUM_SWITCHES-1:0] empty_s, head_s, overflow_s, pop_s;
    logic                      ready_s, grant_valid_s, load_s, take_s;
    logic [c_ID_WIDTH-1:0]     grant_id_s, rr_ptr_r, rr_ptr_n, id_r, id_n;
    logic                      valid_r, valid_n, press_r, press_n;
    int                        best_s, dist_s;
    state_t                    state_r, state_n;

    assign switch_s = bus.i_Switch;
    assign ready_s  = bus.i_Ready;
    assign edge_s   = switch_s ^ prev_r;

    for (genvar i = 0; i < c_NUM_SWITCHES; i++) begin : g_fifo
        switch_event_fifo u_fifo (
            .clk       (i_Clk),
            .rst       (i_Reset),
            .push      (edge_s[i]),
            .push_data (switch_s[i] ? EV_PRESS : EV_RELEASE),
            .pop       (pop_s[i]),
            .empty     (empty_s[i]),
            .head      (head_s[i]),
            .overflow  (overflow_s[i])
        );
    end

    // Round-robin pick: the non-empty FIFO at the smallest distance above the pointer
    always_comb begin
        grant_valid_s = |(~empty_s);
        grant_id_s    = {c_ID_WIDTH{1'b0}};
        best_s        = c_NUM_SWITCHES;
        dist_s        = 0;
        take_s        = 1'b0;
        for (int i = 0; i < c_NUM_SWITCHES; i++) begin
            dist_s     = (i + c_NUM_SWITCHES - int'(rr_ptr_r)) % c_NUM_SWITCHES;
            take_s     = !empty_s[i] && (dist_s < best_s);
            best_s     = take_s ? dist_s : best_s;
            grant_id_s = take_s ? c_ID_WIDTH'(i) : grant_id_s;
        end
    end

    // A grant is loaded whenever the output slot is free or being handed off this edge
    always_comb begin
        load_s = grant_valid_s && ((state_r == ST_IDLE) || ready_s);
        pop_s  = {c_NUM_SWITCHES{1'b0}};
        for (int i = 0; i < c_NUM_SWITCHES; i++) begin
            pop_s[i] = load_s && (grant_id_s == c_ID_WIDTH'(i));
        end
    end

    // Output FSM next state
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE:    state_n = load_s ? ST_PRESENT : ST_IDLE;
            ST_PRESENT: begin
                if (ready_s) begin
                    state_n = load_s ? ST_PRESENT : ST_IDLE;
                end else begin
                    state_n = ST_PRESENT;
                end
            end
            default:    state_n = ST_IDLE;
        endcase
    end

    // Output FSM register contents and round-robin pointer update
    always_comb begin
        valid_n  = valid_r;
        id_n     = id_r;
        press_n  = press_r;
        rr_ptr_n = rr_ptr_r;
        if (load_s) begin
            valid_n  = 1'b1;
            id_n     = grant_id_s;
            press_n  = head_s[grant_id_s];
            rr_ptr_n = (grant_id_s == c_ID_WIDTH'(c_NUM_SWITCHES - 1)) ?
                       {c_ID_WIDTH{1'b0}} : grant_id_s + c_ID_WIDTH'(1);
        end else if ((state_r == ST_PRESENT) && ready_s) begin
            valid_n = 1'b0;
        end else begin
            valid_n = valid_r;
        end
    end

    // State, output and history registers; held switches are absorbed into prev_r on reset
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_r  <= ST_IDLE;
            valid_r  <= 1'b0;
            id_r     <= {c_ID_WIDTH{1'b0}};
            press_r  <= EV_RELEASE;
            rr_ptr_r <= {c_ID_WIDTH{1'b0}};
            prev_r   <= switch_s;
        end else begin
            state_r  <= state_n;
            valid_r  <= valid_n;
            id_r     <= id_n;
            press_r  <= press_n;
            rr_ptr_r <= rr_ptr_n;
            prev_r   <= switch_s;
        end
    end

    assign bus.o_Event_Valid = valid_r;
    assign bus.o_Event_Id    = id_r;
    assign bus.o_Event_Press = press_r;
    assign bus.o_Overflow    = overflow_s;

endmodule
